// File: rtl/main_stream_master_pkg.sv
// Shared definitions for the main_stream_master slice: command constants of the
// `main` core, the sequencer state encoding and the byte-order helper.
package main_stream_master_pkg;

    // Command encoding of the `main` core.
    localparam int MainCMD_SIZE = 4;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_keygen  = 4'd1;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_encrypt = 4'd2;
    localparam logic [MainCMD_SIZE-1:0] MainCMD_decrypt = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_SEND = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Output byte k takes input byte 7-k; host side is little-endian, `main` is not.
    function automatic logic [63:0] byteswap64(input logic [63:0] w);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = w[8*(7-k) +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/main_stream_master_word_counter.sv
// Loadable down-counter used for the remaining input and output word counts.
// It saturates at zero so a stray decrement can never wrap it.
module word_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             is_last,
    output logic             is_zero
);

    logic [CNT_W-1:0] cnt;

    // Count register: load wins over decrement; decrement only while non-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_last = (cnt == CNT_W'(1));
    assign is_zero = (cnt == '0);

endmodule

// File: rtl/main_stream_master.sv
// Host-side master for the `main` core: takes a job descriptor, issues the
// command, streams the input words in and drains the output words, swapping
// byte order on both data paths. Data paths are zero-latency pass-throughs.
//
//   state | meaning
//   IDLE  | waiting for a job descriptor
//   CMD   | offering the latched command to `main`
//   SEND  | passing src words to `main` until inCnt reaches 0
//   RECV  | passing `main` output words to dst until outCnt reaches 0
//   DONE  | one-cycle completion pulse, then back to IDLE
module main_stream_master
    import main_stream_master_pkg::*;
#(
    parameter int CMD_W = MainCMD_SIZE,
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] job_cmd,
    input  logic [CNT_W-1:0] job_inWords,
    input  logic [CNT_W-1:0] job_outWords,
    input  logic             job_isReady,
    output logic             job_canReceive,
    input  logic [63:0]      src_data,
    input  logic             src_isReady,
    output logic             src_canReceive,
    output logic [63:0]      dst_data,
    output logic             dst_isReady,
    input  logic             dst_canReceive,
    output logic [CMD_W-1:0] m_cmd,
    output logic             m_cmd_isReady,
    input  logic             m_cmd_canReceive,
    output logic [63:0]      m_in,
    output logic             m_in_isReady,
    input  logic             m_in_canReceive,
    input  logic [63:0]      m_out,
    input  logic             m_out_isReady,
    output logic             m_out_canReceive,
    output logic             busy,
    output logic             done,
    output logic             protoErr
);

    state_t state;
    logic   job_xfer;
    logic   in_xfer;
    logic   out_xfer;
    logic   in_last;
    logic   in_zero;
    logic   out_last;
    logic   out_zero;
    logic   out_early;

    assign job_xfer  = job_isReady & job_canReceive;
    assign in_xfer   = (state == ST_SEND) & src_isReady & m_in_canReceive;
    assign out_xfer  = (state == ST_RECV) & m_out_isReady & dst_canReceive;
    assign out_early = m_out_isReady &
                       ((state == ST_IDLE) | (state == ST_CMD) | (state == ST_SEND));

    word_counter #(.CNT_W(CNT_W)) u_in_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (job_xfer),
        .load_val (job_inWords),
        .dec      (in_xfer),
        .is_last  (in_last),
        .is_zero  (in_zero)
    );

    word_counter #(.CNT_W(CNT_W)) u_out_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (job_xfer),
        .load_val (job_outWords),
        .dec      (out_xfer),
        .is_last  (out_last),
        .is_zero  (out_zero)
    );

    // Sequencer with registered command/status outputs; m_cmd doubles as the cmd register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            m_cmd          <= '0;
            m_cmd_isReady  <= 1'b0;
            job_canReceive <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            protoErr       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (out_early) begin
                protoErr <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (job_xfer) begin
                        state          <= ST_CMD;
                        m_cmd          <= job_cmd;
                        m_cmd_isReady  <= 1'b1;
                        job_canReceive <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (m_cmd_canReceive) begin
                        m_cmd         <= '0;
                        m_cmd_isReady <= 1'b0;
                        if (!in_zero) begin
                            state <= ST_SEND;
                        end else if (!out_zero) begin
                            state <= ST_RECV;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    if (in_xfer && in_last) begin
                        if (!out_zero) begin
                            state <= ST_RECV;
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (out_xfer && out_last) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state          <= ST_IDLE;
                    job_canReceive <= 1'b1;
                    busy           <= 1'b0;
                end
                default: begin
                    state          <= ST_IDLE;
                    m_cmd          <= '0;
                    m_cmd_isReady  <= 1'b0;
                    job_canReceive <= 1'b1;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

    // Input path: src -> main, only open during SEND.
    always_comb begin
        m_in           = '0;
        m_in_isReady   = 1'b0;
        src_canReceive = 1'b0;
        if (state == ST_SEND) begin
            m_in           = byteswap64(src_data);
            m_in_isReady   = src_isReady;
            src_canReceive = m_in_canReceive;
        end
    end

    // Output path: main -> dst, only open during RECV.
    always_comb begin
        dst_data         = '0;
        dst_isReady      = 1'b0;
        m_out_canReceive = 1'b0;
        if (state == ST_RECV) begin
            dst_data         = byteswap64(m_out);
            dst_isReady      = m_out_isReady;
            m_out_canReceive = dst_canReceive;
        end
    end

endmodule

// File: tb/tb_main_stream_master.sv
// Self-checking bench for main_stream_master: directed job sequence with
// randomized data and handshake readiness, checked against a word-queue model.
module tb_main_stream_master;
    import main_stream_master_pkg::*;

    localparam int CMD_W = MainCMD_SIZE;
    localparam int CNT_W = 20;

    logic             clk;
    logic             rst;
    logic [CMD_W-1:0] job_cmd;
    logic [CNT_W-1:0] job_inWords;
    logic [CNT_W-1:0] job_outWords;
    logic             job_isReady;
    logic             job_canReceive;
    logic [63:0]      src_data;
    logic             src_isReady;
    logic             src_canReceive;
    logic [63:0]      dst_data;
    logic             dst_isReady;
    logic             dst_canReceive;
    logic [CMD_W-1:0] m_cmd;
    logic             m_cmd_isReady;
    logic             m_cmd_canReceive;
    logic [63:0]      m_in;
    logic             m_in_isReady;
    logic             m_in_canReceive;
    logic [63:0]      m_out;
    logic             m_out_isReady;
    logic             m_out_canReceive;
    logic             busy;
    logic             done;
    logic             protoErr;

    int          n_pass = 0;
    int          n_total = 0;
    int          n_fail = 0;
    logic [63:0] src_q[$];
    logic [63:0] mout_q[$];
    logic [63:0] first_min = '0;
    bit          exp_proto = 1'b0;

    main_stream_master #(.CMD_W(CMD_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .job_cmd          (job_cmd),
        .job_inWords      (job_inWords),
        .job_outWords     (job_outWords),
        .job_isReady      (job_isReady),
        .job_canReceive   (job_canReceive),
        .src_data         (src_data),
        .src_isReady      (src_isReady),
        .src_canReceive   (src_canReceive),
        .dst_data         (dst_data),
        .dst_isReady      (dst_isReady),
        .dst_canReceive   (dst_canReceive),
        .m_cmd            (m_cmd),
        .m_cmd_isReady    (m_cmd_isReady),
        .m_cmd_canReceive (m_cmd_canReceive),
        .m_in             (m_in),
        .m_in_isReady     (m_in_isReady),
        .m_in_canReceive  (m_in_canReceive),
        .m_out            (m_out),
        .m_out_isReady    (m_out_isReady),
        .m_out_canReceive (m_out_canReceive),
        .busy             (busy),
        .done             (done),
        .protoErr         (protoErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference byte reversal via the streaming operator.
    function automatic logic [63:0] swap_ref(input logic [63:0] w);
        logic [63:0] r;
        r = {<<8{w}};
        return r;
    endfunction

    function automatic bit rnd(input int rate);
        return int'($urandom_range(0, 99)) < rate;
    endfunction

    task automatic fill(input int nin, input int nout);
        src_q.delete();
        mout_q.delete();
        for (int i = 0; i < nin; i++) src_q.push_back({$urandom, $urandom});
        for (int i = 0; i < nout; i++) mout_q.push_back({$urandom, $urandom});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_cmd"}, 64'(m_cmd), 64'd0);
        check({tag, "_m_in"}, m_in, 64'd0);
        check({tag, "_dst_data"}, dst_data, 64'd0);
        check1({tag, "_job_canReceive"}, job_canReceive, 1'b1);
        check1({tag, "_m_cmd_isReady"}, m_cmd_isReady, 1'b0);
        check1({tag, "_m_in_isReady"}, m_in_isReady, 1'b0);
        check1({tag, "_src_canReceive"}, src_canReceive, 1'b0);
        check1({tag, "_dst_isReady"}, dst_isReady, 1'b0);
        check1({tag, "_m_out_canReceive"}, m_out_canReceive, 1'b0);
        check1({tag, "_busy"}, busy, 1'b0);
        check1({tag, "_done"}, done, 1'b0);
        check1({tag, "_protoErr"}, protoErr, 1'b0);
    endtask

    // Runs one job using src_q/mout_q as the upstream words and the words `main` returns.
    task automatic run_job(input logic [CMD_W-1:0] cmd, input int rate, input int cmd_stall,
                           input int dst_stall, input bit spurious, input int abort_at,
                           input bit check_len);
        int          nin;
        int          nout;
        int          budget;
        int          si, oi, n_cmd, n_min, n_dst, n_done, cyc, done_cyc;
        int          stall_c, dstall_c, inj_stage;
        bit          accepted, cmd_done, finished, aborted, cmd_wait, spur_on, recv_phase;
        bit          saw_src_cr, saw_mout_cr;
        bit          job_x, cmd_x, src_x, mout_x;
        logic [63:0] exp_min[$];
        logic [63:0] exp_dst[$];

        nin = src_q.size();
        nout = mout_q.size();
        budget = 20 * (nin + nout) + 200;
        si = 0; oi = 0; n_cmd = 0; n_min = 0; n_dst = 0; n_done = 0; cyc = 0; done_cyc = -1;
        stall_c = 0; dstall_c = 0; inj_stage = 0;
        accepted = 0; cmd_done = 0; finished = 0; aborted = 0; cmd_wait = 0; spur_on = 0;
        saw_src_cr = 0; saw_mout_cr = 0;
        for (int i = 0; i < nin; i++) exp_min.push_back(swap_ref(src_q[i]));
        for (int i = 0; i < nout; i++) exp_dst.push_back(swap_ref(mout_q[i]));

        @(posedge clk); #1;
        job_cmd = cmd;
        job_inWords = CNT_W'(nin);
        job_outWords = CNT_W'(nout);
        job_isReady = 1'b1;

        for (int t = 0; t < budget && !finished; t++) begin
            @(negedge clk);
            if (accepted) cyc++;
            job_x  = job_isReady && job_canReceive;
            cmd_x  = m_cmd_isReady && m_cmd_canReceive;
            src_x  = src_isReady && src_canReceive;
            mout_x = m_out_isReady && m_out_canReceive;
            if (cmd_x) begin
                n_cmd++;
                check("m_cmd_value", 64'(m_cmd), 64'(cmd));
            end
            if (cmd_wait) check1("m_cmd_isReady_held", m_cmd_isReady, 1'b1);
            cmd_wait = m_cmd_isReady && !m_cmd_canReceive;
            if (src_canReceive) saw_src_cr = 1'b1;
            if (m_out_canReceive) saw_mout_cr = 1'b1;
            if (m_in_isReady && m_in_canReceive) begin
                if (n_min < nin) begin
                    check("m_in_word", m_in, exp_min[n_min]);
                    if (n_min == 0) first_min = m_in;
                end
                n_min++;
            end
            if (dst_isReady && dst_canReceive) begin
                if (n_dst < nout) check("dst_word", dst_data, exp_dst[n_dst]);
                n_dst++;
            end
            if (done) begin
                if (n_done == 0) begin
                    done_cyc = cyc;
                    check1("busy_in_done", busy, 1'b1);
                end
                n_done++;
            end else if (n_done > 0 && job_canReceive) begin
                finished = 1'b1;
            end
            if (inj_stage == 1) begin
                if (!exp_proto) check1("protoErr_not_early", protoErr, 1'b0);
                inj_stage = 2;
            end else if (inj_stage == 2) begin
                check1("protoErr_set", protoErr, 1'b1);
                exp_proto = 1'b1;
                inj_stage = 3;
            end

            @(posedge clk); #1;
            if (job_x && !accepted) begin
                accepted = 1'b1;
                job_isReady = 1'b0;
            end
            if (cmd_x) cmd_done = 1'b1;
            if (abort_at >= 0 && n_dst == abort_at) begin
                rst = 1'b0;
                #1;
                check_reset_outputs("midjob");
                aborted = 1'b1;
                break;
            end
            if (src_x) begin
                si++;
                src_isReady = 1'b0;
            end
            if (!src_isReady && si < nin && rnd(rate)) begin
                src_isReady = 1'b1;
                src_data = src_q[si];
            end
            m_in_canReceive = rnd(rate);
            if (accepted && !cmd_done && stall_c < cmd_stall) begin
                m_cmd_canReceive = 1'b0;
                stall_c++;
            end else begin
                m_cmd_canReceive = rnd(rate);
            end
            if (mout_x) begin
                oi++;
                m_out_isReady = 1'b0;
            end
            if (inj_stage == 2 && spur_on) begin
                m_out_isReady = 1'b0;
                spur_on = 1'b0;
            end
            recv_phase = cmd_done && (n_min >= nin);
            if (spurious && inj_stage == 0 && cmd_done && n_min < nin) begin
                m_out_isReady = 1'b1;
                m_out = '0;
                spur_on = 1'b1;
                inj_stage = 1;
            end else if (!m_out_isReady && recv_phase && oi < nout && rnd(rate)) begin
                m_out_isReady = 1'b1;
                m_out = mout_q[oi];
            end
            if (recv_phase && dstall_c < dst_stall) begin
                dst_canReceive = 1'b0;
                dstall_c++;
            end else begin
                dst_canReceive = rnd(rate);
            end
        end

        src_isReady = 1'b0;
        m_out_isReady = 1'b0;
        job_isReady = 1'b0;
        if (aborted) begin
            m_cmd_canReceive = 1'b0;
            m_in_canReceive = 1'b0;
            dst_canReceive = 1'b0;
            @(posedge clk); #1;
            check1("reset_held_busy", busy, 1'b0);
            rst = 1'b1;
            exp_proto = 1'b0;
            return;
        end

        check1("job_finished_in_budget", finished, 1'b1);
        check("cmd_transfers", 64'(n_cmd), 64'd1);
        check("m_in_transfers", 64'(n_min), 64'(nin));
        check("dst_transfers", 64'(n_dst), 64'(nout));
        check("done_pulses", 64'(n_done), 64'd1);
        if (check_len) check("done_cycle", 64'(done_cyc), 64'(nin + nout + 2));
        if (nin == 0) check1("src_canReceive_never", saw_src_cr, 1'b0);
        if (nout == 0) check1("m_out_canReceive_never", saw_mout_cr, 1'b0);
        check1("protoErr_end", protoErr, exp_proto);
    endtask

    initial begin
        rst = 1'b0;
        job_cmd = '0;
        job_inWords = '0;
        job_outWords = '0;
        job_isReady = 1'b0;
        src_data = '0;
        src_isReady = 1'b0;
        dst_canReceive = 1'b0;
        m_cmd_canReceive = 1'b0;
        m_in_canReceive = 1'b0;
        m_out = '0;
        m_out_isReady = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Normal job; `main` echoes the swapped words back, plus one more.
        src_q.delete();
        mout_q.delete();
        src_q.push_back(64'h0102030405060708);
        src_q.push_back(64'h1111111111111111);
        mout_q.push_back(swap_ref(src_q[0]));
        mout_q.push_back(swap_ref(src_q[1]));
        mout_q.push_back(64'hA1A2A3A4A5A6A7A8);
        run_job(MainCMD_keygen, 100, 0, 0, 1'b0, -1, 1'b1);
        check("m_in_first_word", first_min, 64'h0807060504030201);

        // Zero counts.
        fill(0, 0);
        run_job(MainCMD_encrypt, 100, 0, 0, 1'b0, -1, 1'b1);

        // Backpressure on every channel.
        fill(4, 4);
        run_job(MainCMD_decrypt, 50, 5, 10, 1'b0, -1, 1'b0);

        // Random jobs.
        for (int j = 0; j < 4; j++) begin
            fill(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
            run_job(CMD_W'($urandom_range(1, 3)), 60, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0, -1, 1'b0);
        end

        // Spurious output during SEND, then a job that must keep protoErr high.
        fill(3, 2);
        run_job(MainCMD_keygen, 100, 0, 0, 1'b1, -1, 1'b1);
        fill(2, 2);
        run_job(MainCMD_encrypt, 70, 1, 1, 1'b0, -1, 1'b0);

        // Reset during RECV with five output words still owed.
        fill(1, 8);
        run_job(MainCMD_decrypt, 100, 0, 0, 1'b0, 3, 1'b0);
        fill(1, 1);
        run_job(MainCMD_keygen, 100, 0, 0, 1'b0, -1, 1'b1);

        // Long output-only transfer at full rate.
        fill(0, 30000);
        run_job(MainCMD_encrypt, 100, 0, 0, 1'b0, -1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
